cpu_bus_responder: RTL and testbench
====================================

# cpu_bus_responder

Memory-side responder for the 4-bit CPU's nibble memory bus. It holds the program store and the 16-nibble data RAM, answers fetch and load cycles with a combinational read in the same cycle, and commits store cycles at the clock edge. It sits opposite the CPU tile, for example on the FPGA or bench carrier. A host loader port fills memory before the CPU is released through `cpu_run`.

## Interface
- `PC_BITS`, default 6: program depth is 2^PC_BITS instructions of 3 nibbles each. Allowed range 1..10.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `bus_addr` in 8: CPU `uo_out`. Carries PC[9:2] on fetch cycles and the data address on load/store cycles.
- `bus_ctrl` in 4: CPU `uio_out[7:4]`.
- `bus_wdata` in 4: CPU `uio_out[3:0]`. Valid on store cycles only.
- `bus_rdata` out 4: drives CPU `uio_in[3:0]`.
- `bus_oe` out 1: output enable for `bus_rdata`.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 4, `ld_last` in 1: host nibble loader.
- `reload` in 1: single-cycle pulse that returns the block to LOAD.
- `cpu_run` out 1: drives the CPU `rst_n`.
- `st_valid` out 1, `st_addr` out 4, `st_data` out 4: store trace.
- `err` out 1: sticky bus-protocol error flag.

## Operation
- Cycle decode from `bus_ctrl`:
  - `bus_ctrl[1:0]` = 00, 01 or 10: fetch of instruction nibble `bus_ctrl[1:0]`. PC = {`bus_addr`, `bus_ctrl[3:2]`}.
  - `bus_ctrl` = 0111: load of `dmem[bus_addr[3:0]]`.
  - `bus_ctrl` = 0011: store of `bus_wdata` to `dmem[bus_addr[3:0]]`.
  - Any other code, 1011 or 1111, is illegal.
- Storage:
  - Three program arrays `prog0`, `prog1`, `prog2`, each 2^PC_BITS x 4, indexed by PC.
  - `dmem`, 16 x 4.
  - Reset clears all storage to 0.
- Error conditions. Each sets `err`, and any read returns 0:
  - fetch with PC >= 2^PC_BITS;
  - load or store with `bus_addr[7:4]` != 0;
  - an illegal control code.
  - These checks apply in RUN only. A faulting store does not write.
- State machine, two states:
  - LOAD, the reset state:
    - `ld_ready`=1, `cpu_run`=0, `bus_oe`=0, `bus_rdata`=0.
    - Bus cycles are ignored and no errors are flagged.
    - Each accepted nibble (`ld_valid` and `ld_ready`) is written at the write pointer.
    - Order: `prog0[0]`, `prog1[0]`, `prog2[0]`, `prog0[1]`, and so on through `prog2[last]`, then `dmem[0..15]`.
    - Total is 3*2^PC_BITS + 16 nibbles.
    - The pointer advances by one per accept.
    - Go to RUN after the final nibble is accepted, or after any accepted nibble with `ld_last`=1. Unloaded locations keep their current contents.
  - RUN:
    - `ld_ready`=0, `cpu_run`=1, `bus_oe`=1 except on store cycles, where `bus_oe`=0.
    - `bus_rdata` is the decoded read value, or 0 on store, illegal or faulting cycles.
    - A `reload` pulse returns to LOAD and sets the write pointer to 0. Memory contents are kept.
- `ld_valid` while in RUN is ignored; no write happens.
- `reload` in LOAD sets the pointer to 0 and keeps the state in LOAD.
- If a store and `reload` occur in the same RUN cycle, the store is committed and traced, then the block enters LOAD.
- `err` is cleared only by `rst`.

## Timing
- Read path is combinational, with zero latency. `bus_rdata` and `bus_oe` settle within the same cycle from `bus_addr`, `bus_ctrl`, the current state and the current storage. The CPU samples them at the next edge.
- A store writes `dmem` at the clock edge ending the store cycle. A load in the following cycle returns the new value.
- `st_valid` is registered: it pulses for 1 cycle, the cycle after a committed store, with `st_addr` and `st_data` from that store. It stays 0 otherwise.
- `err` rises the cycle after the faulting bus cycle.
- LOAD to RUN: `cpu_run` rises the cycle after the final accept.
- RUN to LOAD: `cpu_run` falls the cycle after `reload`.
- Reset values, for 1 cycle after `rst` is high at an edge:
  - state LOAD, pointer 0;
  - `ld_ready`=1, `cpu_run`=0, `bus_oe`=0, `bus_rdata`=0;
  - `st_valid`=0, `st_addr`=0, `st_data`=0, `err`=0.
- `rst` asserted mid-load or mid-run overrides everything, including a pending store.

## Test plan
- Reset check: assert `rst` for 2 cycles. Required: `ld_ready`=1, `cpu_run`=0, `bus_oe`=0, `err`=0, and all of `dmem` reads 0 after load.
- Short load and fetch: load 5, A, 3 with `ld_last` on the third nibble. Required: `cpu_run`=1 on the next cycle. Then with `bus_addr`=00:
  - `bus_ctrl`=0000 gives `bus_rdata`=5;
  - `bus_ctrl`=0001 gives A;
  - `bus_ctrl`=0010 gives 3.
- Store then load: `bus_ctrl`=0011, `bus_addr`=07, `bus_wdata`=9. Required: `bus_oe`=0 in that cycle, and the next cycle has `st_valid`=1, `st_addr`=7, `st_data`=9. Then `bus_ctrl`=0111, `bus_addr`=07 gives `bus_rdata`=9 with `bus_oe`=1.
- Full load: send 208 nibbles (PC_BITS=6) with values equal to the index mod 16, and no `ld_last`. Required: automatic RUN after nibble 207. A fetch at PC=1, phase 2 returns 5. A load of `dmem[3]` returns 3, since it is nibble 195.
- Errors:
  - `bus_ctrl`=1011 gives `bus_rdata`=0, and `err`=1 the next cycle; `err` stays 1.
  - A fetch with `bus_addr`=10, `bus_ctrl`=0000 (PC 64) gives 0.
  - A store to `bus_addr`=17 leaves `dmem[7]` unchanged.
- Reload during store: store A to address 2 in the same cycle as `reload`. Required: `st_valid` pulses, `cpu_run`=0, `ld_ready`=1, the next accepted nibble lands in `prog0[0]`, and a later load of `dmem[2]` returns A.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 4-bit CPU nibble bus: holds the program
// store and data RAM, fills them from a host loader, then serves the
// CPU's fetch, load and store cycles.
module cpu_bus_responder #(
    parameter int PC_BITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus_addr,
    input  logic [3:0] bus_ctrl,
    input  logic [3:0] bus_wdata,
    output logic [3:0] bus_rdata,
    output logic       bus_oe,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_data,
    input  logic       ld_last,
    input  logic       reload,
    output logic       cpu_run,
    output logic       st_valid,
    output logic [3:0] st_addr,
    output logic [3:0] st_data,
    output logic       err
);

    localparam int          DEPTH   = 1 << PC_BITS;
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   ld_pc_q, ld_pc_d;     // loader program index
    logic [1:0]           ld_ph_q, ld_ph_d;     // loader nibble phase 0..2
    logic                 ld_dm_q, ld_dm_d;     // loader has reached dmem
    logic [3:0]           ld_di_q, ld_di_d;     // loader dmem index
    logic                 err_q, err_d;
    logic                 st_valid_q, st_valid_d;
    logic [3:0]           st_addr_q, st_addr_d;
    logic [3:0]           st_data_q, st_data_d;

    logic [3:0] prog0_q [DEPTH];
    logic [3:0] prog1_q [DEPTH];
    logic [3:0] prog2_q [DEPTH];
    logic [3:0] dmem_q  [16];

    logic [9:0]         pc;
    logic [PC_BITS-1:0] pc_idx;
    logic               pc_ok, is_fetch, is_load, is_store, fault;
    logic               running, accept, ld_final, st_commit;
    logic               wr_p0, wr_p1, wr_p2, wr_dm;
    logic [3:0]         rd_val;

    // Bus cycle decode and fault detection
    always_comb begin
        pc       = {bus_addr, bus_ctrl[3:2]};
        pc_idx   = pc[PC_BITS-1:0];
        pc_ok    = ({1'b0, pc} < DEPTH_W);
        is_fetch = (bus_ctrl[1:0] != 2'b11);
        is_load  = (bus_ctrl == 4'b0111);
        is_store = (bus_ctrl == 4'b0011);
        fault    = (is_fetch && !pc_ok)
                 || ((is_load || is_store) && (bus_addr[7:4] != 4'h0))
                 || (!is_fetch && !is_load && !is_store);
        running  = (state_q == S_RUN);
        st_commit = running && is_store && !fault;
    end

    // Zero-latency read path; silent outside RUN and on store/fault cycles
    always_comb begin
        rd_val = 4'h0;
        if (is_fetch) begin
            case (bus_ctrl[1:0])
                2'b00:   rd_val = prog0_q[pc_idx];
                2'b01:   rd_val = prog1_q[pc_idx];
                default: rd_val = prog2_q[pc_idx];
            endcase
        end else if (is_load) begin
            rd_val = dmem_q[bus_addr[3:0]];
        end
        bus_oe    = running && !is_store;
        bus_rdata = (running && !is_store && !fault) ? rd_val : 4'h0;
    end

    // Loader pointer walk, write enables and FSM next state
    always_comb begin
        state_d  = state_q;
        ld_pc_d  = ld_pc_q;
        ld_ph_d  = ld_ph_q;
        ld_dm_d  = ld_dm_q;
        ld_di_d  = ld_di_q;
        accept   = ld_valid && !running && !reload;
        ld_final = ld_dm_q && (ld_di_q == 4'hF);
        wr_p0    = accept && !ld_dm_q && (ld_ph_q == 2'd0);
        wr_p1    = accept && !ld_dm_q && (ld_ph_q == 2'd1);
        wr_p2    = accept && !ld_dm_q && (ld_ph_q == 2'd2);
        wr_dm    = accept && ld_dm_q;
        if (reload) begin
            // reload always rewinds the pointer; a nibble offered in the
            // same cycle is dropped so the next accept lands at prog0[0]
            state_d = S_LOAD;
            ld_pc_d = '0;
            ld_ph_d = 2'd0;
            ld_dm_d = 1'b0;
            ld_di_d = 4'h0;
        end else if (accept) begin
            if (ld_dm_q) begin
                if (!ld_final) ld_di_d = ld_di_q + 4'h1;
            end else if (ld_ph_q == 2'd2) begin
                ld_ph_d = 2'd0;
                if (ld_pc_q == PC_BITS'(DEPTH - 1)) ld_dm_d = 1'b1;
                else                                ld_pc_d = ld_pc_q + PC_BITS'(1);
            end else begin
                ld_ph_d = ld_ph_q + 2'd1;
            end
            if (ld_last || ld_final) state_d = S_RUN;
        end
    end

    // Store trace and sticky error next values
    always_comb begin
        err_d      = err_q || (running && fault);
        st_valid_d = st_commit;
        st_addr_d  = st_commit ? bus_addr[3:0] : st_addr_q;
        st_data_d  = st_commit ? bus_wdata     : st_data_q;
    end

    // Control and trace registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ld_pc_q    <= '0;
            ld_ph_q    <= 2'd0;
            ld_dm_q    <= 1'b0;
            ld_di_q    <= 4'h0;
            err_q      <= 1'b0;
            st_valid_q <= 1'b0;
            st_addr_q  <= 4'h0;
            st_data_q  <= 4'h0;
        end else begin
            state_q    <= state_d;
            ld_pc_q    <= ld_pc_d;
            ld_ph_q    <= ld_ph_d;
            ld_dm_q    <= ld_dm_d;
            ld_di_q    <= ld_di_d;
            err_q      <= err_d;
            st_valid_q <= st_valid_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
        end
    end

    // Storage arrays: cleared by reset, written by the loader or by stores
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                prog0_q[i] <= 4'h0;
                prog1_q[i] <= 4'h0;
                prog2_q[i] <= 4'h0;
            end
            for (int i = 0; i < 16; i++) dmem_q[i] <= 4'h0;
        end else begin
            if (wr_p0) prog0_q[ld_pc_q] <= ld_data;
            if (wr_p1) prog1_q[ld_pc_q] <= ld_data;
            if (wr_p2) prog2_q[ld_pc_q] <= ld_data;
            if (wr_dm) dmem_q[ld_di_q] <= ld_data;
            if (st_commit) dmem_q[bus_addr[3:0]] <= bus_wdata;
        end
    end

    assign ld_ready = (state_q == S_LOAD);
    assign cpu_run  = (state_q == S_RUN);
    assign err      = err_q;
    assign st_valid = st_valid_q;
    assign st_addr  = st_addr_q;
    assign st_data  = st_data_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder (PC_BITS = 6).
module tb_cpu_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_addr;
    logic [3:0] bus_ctrl, bus_wdata, bus_rdata;
    logic       bus_oe;
    logic       ld_valid, ld_ready, ld_last, reload, cpu_run;
    logic [3:0] ld_data;
    logic       st_valid, err;
    logic [3:0] st_addr, st_data;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_bus_responder #(.PC_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_oe(bus_oe),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .reload(reload), .cpu_run(cpu_run),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // advance one clock; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [3:0] ctrl, input logic [7:0] addr, input logic [3:0] wd);
        bus_ctrl  = ctrl;
        bus_addr  = addr;
        bus_wdata = wd;
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reload = 1'b0; ld_valid = 1'b0; ld_data = 4'h0; ld_last = 1'b0;
        bus_ctrl = 4'h0; bus_addr = 8'h00; bus_wdata = 4'h0;
        step(); step();
        check("rst_ld_ready", 8'(ld_ready), 8'h1);
        check("rst_cpu_run",  8'(cpu_run),  8'h0);
        check("rst_bus_oe",   8'(bus_oe),   8'h0);
        check("rst_rdata",    8'(bus_rdata), 8'h0);
        check("rst_err",      8'(err),      8'h0);
        check("rst_st_valid", 8'(st_valid), 8'h0);
        rst = 1'b0;

        // short load 5, A, 3 with ld_last on the third nibble
        send(4'h5, 1'b0);
        send(4'hA, 1'b0);
        check("short_still_load", 8'(cpu_run), 8'h0);
        send(4'h3, 1'b1);
        check("short_cpu_run", 8'(cpu_run), 8'h1);
        check("short_ld_ready", 8'(ld_ready), 8'h0);
        bus(4'b0000, 8'h00, 4'h0); check("fetch_ph0", 8'(bus_rdata), 8'h5);
        check("fetch_oe", 8'(bus_oe), 8'h1);
        bus(4'b0001, 8'h00, 4'h0); check("fetch_ph1", 8'(bus_rdata), 8'hA);
        bus(4'b0010, 8'h00, 4'h0); check("fetch_ph2", 8'(bus_rdata), 8'h3);
        for (int i = 0; i < 16; i++) begin
            bus(4'b0111, 8'(i), 4'h0);
            check($sformatf("dmem_clear_%0d", i), 8'(bus_rdata), 8'h0);
        end

        // store 9 to dmem[7], then load it back
        bus(4'b0011, 8'h07, 4'h9);
        check("store_oe", 8'(bus_oe), 8'h0);
        check("store_rdata", 8'(bus_rdata), 8'h0);
        step();
        bus(4'b0111, 8'h07, 4'h0);
        check("st_valid", 8'(st_valid), 8'h1);
        check("st_addr",  8'(st_addr),  8'h7);
        check("st_data",  8'(st_data),  8'h9);
        check("load_after_store", 8'(bus_rdata), 8'h9);
        check("load_oe", 8'(bus_oe), 8'h1);
        step();
        check("st_valid_pulse", 8'(st_valid), 8'h0);

        // reload, then full load of 208 nibbles (index mod 16)
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_cpu_run", 8'(cpu_run), 8'h0);
        check("reload_ld_ready", 8'(ld_ready), 8'h1);
        for (int i = 0; i < 208; i++) begin
            if (i == 207) check("full_before_last", 8'(cpu_run), 8'h0);
            send(4'(i), 1'b0);
        end
        check("full_cpu_run", 8'(cpu_run), 8'h1);
        bus(4'b0110, 8'h00, 4'h0); check("full_pc1_ph2", 8'(bus_rdata), 8'h5);
        bus(4'b1100, 8'h0F, 4'h0); check("full_pc63_ph0", 8'(bus_rdata), 8'hD);
        bus(4'b0111, 8'h03, 4'h0); check("full_dmem3", 8'(bus_rdata), 8'h3);
        bus(4'b0111, 8'h0F, 4'h0); check("full_dmem15", 8'(bus_rdata), 8'hF);
        check("err_before", 8'(err), 8'h0);

        // protocol errors
        bus(4'b1011, 8'h00, 4'h0); check("illegal_rdata", 8'(bus_rdata), 8'h0);
        step();
        bus(4'b0000, 8'h00, 4'h0);
        check("err_rise", 8'(err), 8'h1);
        step();
        check("err_sticky", 8'(err), 8'h1);
        bus(4'b0000, 8'h10, 4'h0); check("fetch_pc64", 8'(bus_rdata), 8'h0);
        bus(4'b0111, 8'h13, 4'h0); check("load_bad_addr", 8'(bus_rdata), 8'h0);
        bus(4'b0011, 8'h17, 4'hE);
        step();
        bus(4'b0111, 8'h07, 4'h0);
        check("bad_store_no_trace", 8'(st_valid), 8'h0);
        check("bad_store_no_write", 8'(bus_rdata), 8'h7);

        // store A to dmem[2] together with reload
        bus(4'b0011, 8'h02, 4'hA);
        reload = 1'b1;
        step();
        reload = 1'b0;
        bus(4'b0000, 8'h00, 4'h0);
        check("rl_st_valid", 8'(st_valid), 8'h1);
        check("rl_st_addr",  8'(st_addr),  8'h2);
        check("rl_st_data",  8'(st_data),  8'hA);
        check("rl_cpu_run",  8'(cpu_run),  8'h0);
        check("rl_ld_ready", 8'(ld_ready), 8'h1);
        check("rl_oe_in_load", 8'(bus_oe), 8'h0);
        send(4'hB, 1'b1);
        check("rl_back_run", 8'(cpu_run), 8'h1);
        bus(4'b0000, 8'h00, 4'h0); check("rl_prog0_0", 8'(bus_rdata), 8'hB);
        bus(4'b0001, 8'h00, 4'h0); check("rl_prog1_0_kept", 8'(bus_rdata), 8'h1);
        bus(4'b0111, 8'h02, 4'h0); check("rl_dmem2", 8'(bus_rdata), 8'hA);

        // loader input in RUN is ignored
        send(4'hF, 1'b1);
        bus(4'b0000, 8'h00, 4'h0); check("run_ld_ignored", 8'(bus_rdata), 8'hB);
        check("run_ld_stay", 8'(cpu_run), 8'h1);

        // reset mid-run clears everything, including a pending store
        bus(4'b0011, 8'h05, 4'h6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_st_valid", 8'(st_valid), 8'h0);
        check("rst2_err", 8'(err), 8'h0);
        check("rst2_cpu_run", 8'(cpu_run), 8'h0);
        send(4'h1, 1'b1);
        bus(4'b0111, 8'h05, 4'h0); check("rst2_dmem5", 8'(bus_rdata), 8'h0);
        bus(4'b0111, 8'h02, 4'h0); check("rst2_dmem2", 8'(bus_rdata), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
